// File: rtl/e203_exu_oitf_sched_pkg.sv
// rtl/e203_exu_oitf_sched_pkg.sv - shared sizing for the long-pipe outstanding-instruction tracker
package e203_exu_oitf_sched_pkg;

  localparam int E203_OITF_DEPTH  = 2;
  localparam int E203_ITAG_WIDTH  = 1;
  localparam int E203_RFIDX_WIDTH = 5;
  localparam int E203_PC_SIZE     = 32;

endpackage

// File: rtl/e203_oitf_ptr.sv
// rtl/e203_oitf_ptr.sv - circular pointer with a wrap flag that toggles on each lap
module e203_oitf_ptr #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr,
  output logic             flg
);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             flg_q, flg_d;

  always_comb begin
    ptr_d = ptr_q;
    flg_d = flg_q;
    if (inc) begin
      if (ptr_q == PTR_W'(DEPTH - 1)) begin
        ptr_d = '0;
        flg_d = ~flg_q;
      end else begin
        ptr_d = ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      flg_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      flg_q <= flg_d;
    end
  end

  assign ptr = ptr_q;
  assign flg = flg_q;

endmodule

// File: rtl/e203_exu_oitf_sched.sv
// rtl/e203_exu_oitf_sched.sv - in-order tracking buffer for long-pipe instructions with hazard flags
module e203_exu_oitf_sched
  import e203_exu_oitf_sched_pkg::*;
#(
  parameter int DEPTH   = E203_OITF_DEPTH,
  parameter int PTR_W   = E203_ITAG_WIDTH,
  parameter int RFIDX_W = E203_RFIDX_WIDTH,
  parameter int PC_W    = E203_PC_SIZE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dis_ena,
  output logic               dis_ready,
  input  logic [RFIDX_W-1:0] dis_rdidx,
  input  logic               dis_rdwen,
  input  logic               dis_rdfpu,
  input  logic [PC_W-1:0]    dis_pc,
  output logic [PTR_W-1:0]   dis_ptr,
  input  logic               ret_ena,
  output logic [PTR_W-1:0]   ret_ptr,
  output logic [RFIDX_W-1:0] ret_rdidx,
  output logic               ret_rdwen,
  output logic               ret_rdfpu,
  output logic [PC_W-1:0]    ret_pc,
  output logic               empty,
  output logic               full,
  input  logic               chk_rs1en,
  input  logic               chk_rs2en,
  input  logic               chk_rs3en,
  input  logic               chk_rdwen,
  input  logic               chk_rs1fpu,
  input  logic               chk_rs2fpu,
  input  logic               chk_rs3fpu,
  input  logic               chk_rdfpu,
  input  logic [RFIDX_W-1:0] chk_rs1idx,
  input  logic [RFIDX_W-1:0] chk_rs2idx,
  input  logic [RFIDX_W-1:0] chk_rs3idx,
  input  logic [RFIDX_W-1:0] chk_rdidx,
  output logic               oitfrd_match_rs1,
  output logic               oitfrd_match_rs2,
  output logic               oitfrd_match_rs3,
  output logic               oitfrd_match_rd,
  output logic               dep
);

  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               wr_flg, rd_flg;
  logic               alc, ret;
  logic               vld_q [DEPTH];
  logic               vld_d [DEPTH];
  logic [RFIDX_W-1:0] rdidx_q [DEPTH];
  logic               rdwen_q [DEPTH];
  logic               rdfpu_q [DEPTH];
  logic [PC_W-1:0]    pc_q [DEPTH];

  assign empty     = (wr_ptr == rd_ptr) & (wr_flg == rd_flg);
  assign full      = (wr_ptr == rd_ptr) & (wr_flg != rd_flg);
  assign dis_ready = ~full;
  assign alc       = dis_ena & ~full;
  assign ret       = ret_ena & ~empty;

  e203_oitf_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk(clk), .rst_n(rst_n), .inc(alc), .ptr(wr_ptr), .flg(wr_flg)
  );

  e203_oitf_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk(clk), .rst_n(rst_n), .inc(ret), .ptr(rd_ptr), .flg(rd_flg)
  );

  // alc and ret never target the same slot: that needs wr_ptr==rd_ptr, i.e. empty or full
  always_comb begin
    for (int e = 0; e < DEPTH; e++) vld_d[e] = vld_q[e];
    if (ret) vld_d[rd_ptr] = 1'b0;
    if (alc) vld_d[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        vld_q[e]   <= 1'b0;
        rdidx_q[e] <= '0;
        rdwen_q[e] <= 1'b0;
        rdfpu_q[e] <= 1'b0;
        pc_q[e]    <= '0;
      end
    end else begin
      for (int e = 0; e < DEPTH; e++) vld_q[e] <= vld_d[e];
      if (alc) begin
        rdidx_q[wr_ptr] <= dis_rdidx;
        rdwen_q[wr_ptr] <= dis_rdwen;
        rdfpu_q[wr_ptr] <= dis_rdfpu;
        pc_q[wr_ptr]    <= dis_pc;
      end
    end
  end

  assign dis_ptr   = wr_ptr;
  assign ret_ptr   = rd_ptr;
  assign ret_rdidx = rdidx_q[rd_ptr];
  assign ret_rdwen = rdwen_q[rd_ptr];
  assign ret_rdfpu = rdfpu_q[rd_ptr];
  assign ret_pc    = pc_q[rd_ptr];

  always_comb begin
    oitfrd_match_rs1 = 1'b0;
    oitfrd_match_rs2 = 1'b0;
    oitfrd_match_rs3 = 1'b0;
    oitfrd_match_rd  = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      if (vld_q[e] & rdwen_q[e]) begin
        oitfrd_match_rs1 |= chk_rs1en & (chk_rs1idx == rdidx_q[e]) & (chk_rs1fpu == rdfpu_q[e]);
        oitfrd_match_rs2 |= chk_rs2en & (chk_rs2idx == rdidx_q[e]) & (chk_rs2fpu == rdfpu_q[e]);
        oitfrd_match_rs3 |= chk_rs3en & (chk_rs3idx == rdidx_q[e]) & (chk_rs3fpu == rdfpu_q[e]);
        oitfrd_match_rd  |= chk_rdwen & (chk_rdidx  == rdidx_q[e]) & (chk_rdfpu  == rdfpu_q[e]);
      end
    end
  end

  assign dep = oitfrd_match_rs1 | oitfrd_match_rs2 | oitfrd_match_rs3 | oitfrd_match_rd;

  // Dispatch against a full buffer is only tolerated while the same cycle retires (it is dropped)
  a_dis_when_full: assert property (@(posedge clk) disable iff (!rst_n) (dis_ena & full) |-> ret_ena);
  a_ret_when_empty: assert property (@(posedge clk) disable iff (!rst_n) !(ret_ena & empty));

endmodule

// File: tb/tb_e203_exu_oitf_sched.sv
// tb/tb_e203_exu_oitf_sched.sv - scoreboard bench for the long-pipe outstanding-instruction tracker
module tb_e203_exu_oitf_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dis_ena, dis_ready, dis_rdwen, dis_rdfpu;
  logic [4:0]  dis_rdidx;
  logic [31:0] dis_pc;
  logic        dis_ptr, ret_ena, ret_ptr, ret_rdwen, ret_rdfpu;
  logic [4:0]  ret_rdidx;
  logic [31:0] ret_pc;
  logic        empty, full;
  logic        chk_rs1en, chk_rs2en, chk_rs3en, chk_rdwen;
  logic        chk_rs1fpu, chk_rs2fpu, chk_rs3fpu, chk_rdfpu;
  logic [4:0]  chk_rs1idx, chk_rs2idx, chk_rs3idx, chk_rdidx;
  logic        m_rs1, m_rs2, m_rs3, m_rd, dep;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        itag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic wptr;

  always #5 clk = ~clk;

  e203_exu_oitf_sched dut (
    .clk(clk), .rst_n(rst_n),
    .dis_ena(dis_ena), .dis_ready(dis_ready), .dis_rdidx(dis_rdidx), .dis_rdwen(dis_rdwen),
    .dis_rdfpu(dis_rdfpu), .dis_pc(dis_pc), .dis_ptr(dis_ptr),
    .ret_ena(ret_ena), .ret_ptr(ret_ptr), .ret_rdidx(ret_rdidx), .ret_rdwen(ret_rdwen),
    .ret_rdfpu(ret_rdfpu), .ret_pc(ret_pc), .empty(empty), .full(full),
    .chk_rs1en(chk_rs1en), .chk_rs2en(chk_rs2en), .chk_rs3en(chk_rs3en), .chk_rdwen(chk_rdwen),
    .chk_rs1fpu(chk_rs1fpu), .chk_rs2fpu(chk_rs2fpu), .chk_rs3fpu(chk_rs3fpu), .chk_rdfpu(chk_rdfpu),
    .chk_rs1idx(chk_rs1idx), .chk_rs2idx(chk_rs2idx), .chk_rs3idx(chk_rs3idx), .chk_rdidx(chk_rdidx),
    .oitfrd_match_rs1(m_rs1), .oitfrd_match_rs2(m_rs2), .oitfrd_match_rs3(m_rs3),
    .oitfrd_match_rd(m_rd), .dep(dep)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle that will retire, the oldest entry must match the scoreboard head
  always @(negedge clk) begin
    if (rst_n && ret_ena && !empty) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ret_unexpected: got pc 0x%0h expected no outstanding entry", ret_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ret_pc", ret_pc, e.pc);
        chk("ret_rdidx", 32'(ret_rdidx), 32'(e.rd));
        chk("ret_ptr", 32'(ret_ptr), 32'(e.itag));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dis_ena = 1'b0;
    ret_ena = 1'b0;
  endtask

  task automatic drv_dis(input logic [4:0] rd, input logic [31:0] pc, input logic wen, input logic fpu);
    dis_ena   = 1'b1;
    dis_rdidx = rd;
    dis_pc    = pc;
    dis_rdwen = wen;
    dis_rdfpu = fpu;
  endtask

  task automatic push(input logic [31:0] pc, input logic [4:0] rd, input logic itag);
    exp_t e;
    e.pc = pc;
    e.rd = rd;
    e.itag = itag;
    sb.push_back(e);
  endtask

  // en/fpu/exp ordered {rs1, rs2, rs3, rd}
  task automatic hz(input string name, input logic [3:0] en, input logic [3:0] fpu,
                    input logic [4:0] i1, input logic [4:0] i2, input logic [4:0] i3,
                    input logic [4:0] ird, input logic [3:0] exp);
    {chk_rs1en, chk_rs2en, chk_rs3en, chk_rdwen}     = en;
    {chk_rs1fpu, chk_rs2fpu, chk_rs3fpu, chk_rdfpu} = fpu;
    chk_rs1idx = i1;
    chk_rs2idx = i2;
    chk_rs3idx = i3;
    chk_rdidx  = ird;
    @(negedge clk);
    chk({name, "_match"}, 32'({m_rs1, m_rs2, m_rs3, m_rd}), 32'(exp));
    chk({name, "_dep"}, 32'(dep), 32'(|exp));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    idle();
    dis_rdidx = '0; dis_pc = '0; dis_rdwen = 1'b0; dis_rdfpu = 1'b0;
    {chk_rs1en, chk_rs2en, chk_rs3en, chk_rdwen}     = 4'b0;
    {chk_rs1fpu, chk_rs2fpu, chk_rs3fpu, chk_rdfpu} = 4'b0;
    chk_rs1idx = '0; chk_rs2idx = '0; chk_rs3idx = '0; chk_rdidx = '0;
    #3;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    @(negedge clk);
    chk("idle_empty", 32'(empty), 1);
    chk("idle_full", 32'(full), 0);
    chk("idle_dis_ready", 32'(dis_ready), 1);
    chk("idle_dis_ptr", 32'(dis_ptr), 0);
    chk("idle_ret_ptr", 32'(ret_ptr), 0);
    chk("idle_dep", 32'(dep), 0);
    chk("idle_ret_pc", ret_pc, 0);
    tick();

    // Fill both entries
    drv_dis(5'd5, 32'h100, 1'b1, 1'b0);
    @(negedge clk);
    chk("fill0_dis_ptr", 32'(dis_ptr), 0);
    push(32'h100, 5'd5, 1'b0);
    tick();
    drv_dis(5'd6, 32'h104, 1'b1, 1'b0);
    @(negedge clk);
    chk("fill1_dis_ptr", 32'(dis_ptr), 1);
    chk("fill1_dis_ready", 32'(dis_ready), 1);
    push(32'h104, 5'd6, 1'b1);
    tick();
    idle();
    @(negedge clk);
    chk("full_full", 32'(full), 1);
    chk("full_dis_ready", 32'(dis_ready), 0);
    chk("full_empty", 32'(empty), 0);
    chk("full_ret_rdidx", 32'(ret_rdidx), 5);
    chk("full_ret_pc", ret_pc, 32'h100);
    tick();

    // Full with simultaneous dispatch and retire: only the retire fires
    drv_dis(5'd9, 32'h200, 1'b1, 1'b0);
    ret_ena = 1'b1;
    @(negedge clk);
    chk("simul_dis_ready", 32'(dis_ready), 0);
    tick();
    idle();
    @(negedge clk);
    chk("after_ret_ptr", 32'(ret_ptr), 1);
    chk("after_ret_rdidx", 32'(ret_rdidx), 6);
    chk("after_ret_pc", ret_pc, 32'h104);
    chk("after_full", 32'(full), 0);
    chk("after_dis_ready", 32'(dis_ready), 1);
    tick();
    drv_dis(5'd7, 32'h108, 1'b1, 1'b1);
    @(negedge clk);
    chk("wrap_dis_ptr", 32'(dis_ptr), 0);
    push(32'h108, 5'd7, 1'b0);
    tick();
    idle();
    @(negedge clk);
    chk("wrap_full", 32'(full), 1);
    tick();

    // Make the outstanding set rd=7 fpu (oldest) and rd=5 int
    ret_ena = 1'b1;
    tick();
    idle();
    drv_dis(5'd5, 32'h10c, 1'b1, 1'b0);
    @(negedge clk);
    chk("hz_setup_dis_ptr", 32'(dis_ptr), 1);
    push(32'h10c, 5'd5, 1'b1);
    tick();
    idle();

    hz("hz_rs1_int5", 4'b1000, 4'b0000, 5'd5, 5'd0, 5'd0, 5'd0, 4'b1000);
    hz("hz_rs2_int7", 4'b0100, 4'b0000, 5'd0, 5'd7, 5'd0, 5'd0, 4'b0000);
    hz("hz_rd_fpu7", 4'b0001, 4'b0001, 5'd0, 5'd0, 5'd0, 5'd7, 4'b0001);
    hz("hz_rs3_fpu5", 4'b0010, 4'b0010, 5'd0, 5'd0, 5'd5, 5'd0, 4'b0000);
    hz("hz_rs1_off", 4'b0000, 4'b0000, 5'd5, 5'd0, 5'd0, 5'd0, 4'b0000);
    hz("hz_all", 4'b1111, 4'b0101, 5'd5, 5'd7, 5'd5, 5'd7, 4'b1111);

    // Replace rd=7 with an entry that does not write rd
    {chk_rs1en, chk_rs2en, chk_rs3en, chk_rdwen} = 4'b0;
    ret_ena = 1'b1;
    tick();
    idle();
    drv_dis(5'd9, 32'h110, 1'b0, 1'b0);
    @(negedge clk);
    chk("nowen_dis_ptr", 32'(dis_ptr), 0);
    push(32'h110, 5'd9, 1'b0);
    tick();
    idle();
    hz("hz_nowen9", 4'b1100, 4'b0000, 5'd9, 5'd5, 5'd0, 5'd0, 4'b0100);
    hz("hz_gone7", 4'b0001, 4'b0001, 5'd0, 5'd0, 5'd0, 5'd7, 4'b0000);

    ret_ena = 1'b1;
    tick();
    tick();
    idle();
    @(negedge clk);
    chk("drain_empty", 32'(empty), 1);
    tick();

    // Wrap soak: one outstanding, dispatch and retire every cycle
    wptr = 1'b1;
    drv_dis(5'd10, 32'h1000, 1'b1, 1'b0);
    @(negedge clk);
    chk("soak0_dis_ptr", 32'(dis_ptr), 32'(wptr));
    push(32'h1000, 5'd10, wptr);
    wptr = ~wptr;
    tick();
    for (int i = 1; i <= 10; i++) begin
      drv_dis(5'(10 + i), 32'h1000 + 32'(4 * i), 1'b1, 1'b0);
      ret_ena = 1'b1;
      @(negedge clk);
      chk("soak_dis_ptr", 32'(dis_ptr), 32'(wptr));
      chk("soak_empty_and_full", 32'(empty & full), 0);
      push(32'h1000 + 32'(4 * i), 5'(10 + i), wptr);
      wptr = ~wptr;
      tick();
    end
    dis_ena = 1'b0;
    ret_ena = 1'b1;
    tick();
    idle();
    @(negedge clk);
    chk("soak_drained", 32'(empty), 1);
    tick();

    // Async reset with two entries valid
    drv_dis(5'd3, 32'h2000, 1'b1, 1'b0);
    push(32'h2000, 5'd3, wptr);
    tick();
    drv_dis(5'd4, 32'h2004, 1'b1, 1'b1);
    tick();
    idle();
    @(negedge clk);
    chk("pre_rst_full", 32'(full), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_empty", 32'(empty), 1);
    chk("arst_full", 32'(full), 0);
    chk("arst_dis_ready", 32'(dis_ready), 1);
    chk("arst_dis_ptr", 32'(dis_ptr), 0);
    chk("arst_ret_ptr", 32'(ret_ptr), 0);
    chk("arst_ret_pc", ret_pc, 0);
    chk("arst_ret_rdidx", 32'(ret_rdidx), 0);
    chk("arst_ret_rdwen", 32'(ret_rdwen), 0);
    chk("arst_ret_rdfpu", 32'(ret_rdfpu), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drv_dis(5'd8, 32'h3000, 1'b1, 1'b1);
    @(negedge clk);
    chk("post_rst_dis_ptr", 32'(dis_ptr), 0);
    push(32'h3000, 5'd8, 1'b0);
    tick();
    idle();
    ret_ena = 1'b1;
    tick();
    idle();
    @(negedge clk);
    chk("final_empty", 32'(empty), 1);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
